baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Parametrised, runtime-programmable baud generator for the UART controller. It produces three single-cycle enable ticks: oversample rate, bit rate and bit centre. It also produces a legacy bit-rate square wave. The divisor has integer and fractional parts and is loaded through a valid/ready handshake, so the rate can change without glitching a bit in flight. It sits between the system clock and the TX/RX shifters, and one instance serves one TX/RX pair.

## Interface
- `DIV_W`, 16: width of the integer divisor, in system clocks per oversample tick.
- `FRAC_W`, 4: width of the fractional divisor; a step is 1/2^FRAC_W clock.
- `OVS`, 16: oversample ticks per bit; must be a power of two, at least 4.
- `DEFAULT_DIV`, 326: integer divisor after reset; the fraction after reset is 0.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: run enable; when low, all counters freeze.
- `resync`, in, 1: pulse that restarts the bit phase (RX start-bit alignment).
- `cfg_valid`, in, 1: new divisor offered.
- `cfg_ready`, out, 1: block can accept a divisor.
- `cfg_div_int`, in, DIV_W: new integer divisor.
- `cfg_div_frac`, in, FRAC_W: new fractional divisor.
- `os_tick`, out, 1: oversample tick, one-cycle pulse.
- `bit_tick`, out, 1: bit-boundary tick, one-cycle pulse.
- `mid_tick`, out, 1: bit-centre tick, one-cycle pulse.
- `bclk`, out, 1: bit-rate square wave, high in the first half of the bit.
- `os_cnt`, out, log2(OVS): current oversample phase within the bit.

## Operation
- **Active divisor:** `div_int`/`div_frac`; any `div_int` below 2 is treated as 2.
- **Period counter:** down-counter `cnt`. When `cnt==0` and `en`:
  - `acc <= acc + div_frac`, with carry out of FRAC_W bits;
  - `cnt <= div_int + carry - 1`;
  - `os_tick` is raised for the next cycle.
- **Average period:** `div_int + div_frac/2^FRAC_W` clocks.
- **Phase counter:** `os_cnt` advances modulo OVS on each oversample event.
  - `bit_tick` pulses with the `os_tick` whose event wraps `os_cnt` from OVS-1 to 0.
  - `mid_tick` pulses with the `os_tick` whose event sets `os_cnt` to OVS/2.
- **`bclk`:** equals `os_cnt < OVS/2`, registered.
- **Config handshake:**
  - A transfer occurs when `cfg_valid && cfg_ready`; the divisor is latched as pending and `cfg_ready` drops.
  - The pending divisor becomes active on the next bit-boundary event, or on the next cycle if `en` is low.
  - On activation, `acc` clears to 0, `cnt` loads the new `div_int-1`, and `cfg_ready` rises the following cycle.
- **`en` low:** `cnt`, `acc` and `os_cnt` hold; no ticks; `bclk` holds.
- **`resync` (when `en` high):**
  - `cnt` reloads to `div_int-1` and `acc` clears;
  - `os_cnt` goes to 0 and no tick is raised that cycle;
  - a pending divisor is activated at the same time.
- **Resync vs. tick:** if `resync` coincides with `cnt==0`, `resync` wins and no tick is produced.
- **Reset:**
  - `cnt=DEFAULT_DIV-1`, `acc=0`, `os_cnt=0`;
  - all ticks 0, `bclk=1`, `cfg_ready=1`;
  - any pending config is discarded and the active divisor returns to `DEFAULT_DIV` with fraction 0.
  - Reset mid-bit or mid-handshake behaves identically.

## Timing
- All outputs are registered.
- Each tick is high for exactly one cycle; `bit_tick` and `mid_tick` are never high without `os_tick`.
- Take cycle 0 as the first cycle after `rst` falls, with `en` held high and divisor D with fraction 0:
  - `os_tick` is high in cycles D, 2D, 3D, …
  - `bit_tick` is high in cycle OVS·D;
  - `mid_tick` is high in cycle (OVS/2)·D.
- The first post-`resync` `os_tick` comes `div_int` cycles after the `resync` cycle.
- `cfg_ready` is low from the cycle after acceptance through the activation cycle.

## Structure
- **Shared header `baud_defs`:** holds `OVS` and the standard divisor constants for 50 MHz (9600, 19200, 115200), so TX, RX and the testbench agree.
- **Sub-module `frac_period_ctr`:** contains `cnt`, `acc` and the carry logic; it outputs the raw oversample event and accepts reload/clear.
- **Top level:** contains the phase counter, the tick and `bclk` registers, and the config handshake.

## Test plan
- **Integer divisor:** `DEFAULT_DIV=4`, `OVS=16`, `en=1` → `os_tick` every 4 cycles starting at cycle 4; `mid_tick` at cycle 32; `bit_tick` at 64 and 128; `bclk` high for 32 cycles, low for 32.
- **Fractional divisor:** load `div_int=3`, `div_frac=8` (FRAC_W=4), then `resync` → oversample periods alternate 3,4,3,4…; exactly 16 `os_tick`s in 56 cycles, with `bit_tick` on the 16th.
- **Config mid-bit:** `cfg_valid` accepted at `os_cnt=5` → `cfg_ready` stays low until the bit-boundary event; the old period holds until then and the new period applies from the next event; a second `cfg_valid` is not accepted while low.
- **`en` and `resync` corner cases:**
  - `en` low for 10 cycles → counters frozen and no ticks; resuming continues the same phase.
  - `resync` on a `cnt==0` cycle → no tick; next `os_tick` `div_int` cycles later with `os_cnt=0`.
- **Clamp and reset:**
  - `cfg_div_int=0` → behaves as a divisor of 2.
  - `rst` mid-bit with a config pending → all outputs return to reset values, the pending config is dropped, and timing restarts as in the integer-divisor scenario.

Source files
------------

// File: rtl/baud_tick_gen_pkg.sv
// Shared UART baud constants: default oversample ratio, standard 50 MHz divisors
// and the config-handshake state type.
package baud_tick_gen_pkg;

  localparam int OVS_STD    = 16;
  localparam int CLK_HZ_STD = 50_000_000;

  // Divisor = CLK_HZ_STD / (baud * OVS_STD), split into integer and 1/16 parts
  localparam int DIV_9600_INT    = 325;
  localparam int DIV_9600_FRAC   = 8;
  localparam int DIV_19200_INT   = 162;
  localparam int DIV_19200_FRAC  = 12;
  localparam int DIV_115200_INT  = 27;
  localparam int DIV_115200_FRAC = 2;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_t;

endpackage

// File: rtl/baud_tick_gen_if.sv
// Divisor configuration channel: valid/ready handshake carrying integer and
// fractional divisor parts.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;

  modport master (
    output cfg_valid,
    output cfg_div_int,
    output cfg_div_frac,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div_int,
    input  cfg_div_frac,
    output cfg_ready
  );
endinterface

// File: rtl/baud_tick_gen_frac_period_ctr.sv
// Fractional period counter: down-counter plus fraction accumulator whose carry
// stretches a period by one clock; flags the raw oversample event at cnt==0.
module baud_tick_gen_frac_period_ctr #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int RST_CNT = 325
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              reload,
  input  logic [DIV_W-1:0]  reload_val,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              ev
);

  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic              carry;

  assign ev = en && (cnt_reg == '0);

  // A reload overrides the event update, so resync/activation always wins.
  always_comb begin
    cnt_next = cnt_reg;
    acc_next = acc_reg;
    carry    = 1'b0;
    if (reload) begin
      cnt_next = reload_val;
      acc_next = '0;
    end else if (ev) begin
      {carry, acc_next} = {1'b0, acc_reg} + {1'b0, div_frac};
      cnt_next          = div_int + DIV_W'(carry) - DIV_W'(1);
    end else if (en) begin
      cnt_next = cnt_reg - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= DIV_W'(RST_CNT);
      acc_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// UART baud generator: oversample/bit/mid-bit ticks, bit-rate square wave and a
// divisor that is swapped in only at bit boundaries (or immediately when idle).
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVS         = OVS_STD,
  parameter int DEFAULT_DIV = 326
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    resync,
  baud_tick_gen_if.slave          cfg,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic                    mid_tick,
  output logic                    bclk,
  output logic [$clog2(OVS)-1:0]  os_cnt
);

  localparam int OS_W    = $clog2(OVS);
  localparam int DEF_DIV = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2);
  localparam logic [OS_W-1:0] OS_PRE_MID = OS_W'(OVS / 2 - 1);

  cfg_state_t        state_reg, state_next;
  logic [DIV_W-1:0]  div_int_reg, div_int_next;
  logic [FRAC_W-1:0] div_frac_reg, div_frac_next;
  logic [DIV_W-1:0]  pend_int_reg, pend_int_next;
  logic [FRAC_W-1:0] pend_frac_reg, pend_frac_next;
  logic [OS_W-1:0]   os_cnt_reg, os_cnt_next;
  logic              os_tick_reg, os_tick_next;
  logic              bit_tick_reg, bit_tick_next;
  logic              mid_tick_reg, mid_tick_next;
  logic              bclk_reg, bclk_next;

  logic              ev_raw;
  logic              resync_act;
  logic              os_ev;
  logic              boundary;
  logic              activate;
  logic              reload;
  logic [DIV_W-1:0]  sel_int;
  logic [DIV_W-1:0]  reload_val;
  logic [DIV_W-1:0]  cfg_int_clamped;

  baud_tick_gen_frac_period_ctr #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (DEF_DIV - 1)
  ) u_period (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .reload     (reload),
    .reload_val (reload_val),
    .div_int    (div_int_reg),
    .div_frac   (div_frac_reg),
    .ev         (ev_raw)
  );

  assign cfg_int_clamped = (cfg.cfg_div_int < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div_int;

  assign resync_act = en && resync;
  assign os_ev      = ev_raw && !resync;
  assign boundary   = os_ev && (os_cnt_reg == OS_LAST);
  assign activate   = (state_reg == CFG_PEND) && (resync_act || boundary || !en);
  assign sel_int    = activate ? pend_int_reg : div_int_reg;
  assign reload     = resync_act || activate;
  // The resync cycle counts as the first clock of the restarted period.
  assign reload_val = resync_act ? (sel_int - DIV_W'(2)) : (sel_int - DIV_W'(1));

  always_comb begin
    state_next     = state_reg;
    div_int_next   = div_int_reg;
    div_frac_next  = div_frac_reg;
    pend_int_next  = pend_int_reg;
    pend_frac_next = pend_frac_reg;
    case (state_reg)
      CFG_IDLE: begin
        if (cfg.cfg_valid) begin
          state_next     = CFG_PEND;
          pend_int_next  = cfg_int_clamped;
          pend_frac_next = cfg.cfg_div_frac;
        end
      end
      CFG_PEND: begin
        if (activate) begin
          state_next    = CFG_IDLE;
          div_int_next  = pend_int_reg;
          div_frac_next = pend_frac_reg;
        end
      end
      default: state_next = CFG_IDLE;
    endcase
  end

  always_comb begin
    os_cnt_next = os_cnt_reg;
    if (resync_act) begin
      os_cnt_next = '0;
    end else if (os_ev) begin
      os_cnt_next = os_cnt_reg + OS_W'(1);
    end
    os_tick_next  = os_ev;
    bit_tick_next = boundary;
    mid_tick_next = os_ev && (os_cnt_reg == OS_PRE_MID);
    bclk_next     = (os_cnt_next < OS_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CFG_IDLE;
      div_int_reg   <= DIV_W'(DEF_DIV);
      div_frac_reg  <= '0;
      pend_int_reg  <= '0;
      pend_frac_reg <= '0;
      os_cnt_reg    <= '0;
      os_tick_reg   <= 1'b0;
      bit_tick_reg  <= 1'b0;
      mid_tick_reg  <= 1'b0;
      bclk_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      div_int_reg   <= div_int_next;
      div_frac_reg  <= div_frac_next;
      pend_int_reg  <= pend_int_next;
      pend_frac_reg <= pend_frac_next;
      os_cnt_reg    <= os_cnt_next;
      os_tick_reg   <= os_tick_next;
      bit_tick_reg  <= bit_tick_next;
      mid_tick_reg  <= mid_tick_next;
      bclk_reg      <= bclk_next;
    end
  end

  assign cfg.cfg_ready = (state_reg == CFG_IDLE);
  assign os_tick       = os_tick_reg;
  assign bit_tick      = bit_tick_reg;
  assign mid_tick      = mid_tick_reg;
  assign bclk          = bclk_reg;
  assign os_cnt        = os_cnt_reg;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: integer/fractional timing, mid-bit config,
// enable freeze, resync, divisor clamp and reset with a pending config.
module tb_baud_tick_gen;
  import baud_tick_gen_pkg::*;

  localparam int D0 = 4;
  localparam int FR_TICKS [16] = '{3, 6, 10, 13, 17, 20, 24, 27, 31, 34, 38, 41, 45, 48, 52, 55};

  logic       clk = 1'b0;
  logic       rst, en, resync;
  logic       os_tick, bit_tick, mid_tick, bclk;
  logic [3:0] os_cnt;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last, saved_os, cnt_ticks, found;
  logic       saved_bclk;

  baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) cfg_if ();

  baud_tick_gen #(
    .DIV_W       (16),
    .FRAC_W      (4),
    .OVS         (OVS_STD),
    .DEFAULT_DIV (D0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .resync   (resync),
    .cfg      (cfg_if),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .bclk     (bclk),
    .os_cnt   (os_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("tick_nest", 32'((bit_tick | mid_tick) & ~os_tick), 0);
  endtask

  task automatic check_reset();
    chk("rst_os_tick", 32'(os_tick), 0);
    chk("rst_bit_tick", 32'(bit_tick), 0);
    chk("rst_mid_tick", 32'(mid_tick), 0);
    chk("rst_bclk", 32'(bclk), 1);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    chk("rst_os_cnt", 32'(os_cnt), 0);
  endtask

  // Default divisor of 4, cycle 0 being the first cycle out of reset.
  task automatic run_int(input int n);
    repeat (n) begin
      step();
      chk("int_os_tick", 32'(os_tick), 32'(cyc % 4 == 0));
      chk("int_bit_tick", 32'(bit_tick), 32'(cyc % 64 == 0));
      chk("int_mid_tick", 32'(mid_tick), 32'(cyc % 64 == 32));
      chk("int_os_cnt", 32'(os_cnt), 32'((cyc / 4) % 16));
      chk("int_bclk", 32'(bclk), 32'(((cyc / 4) % 16) < 8));
    end
  endtask

  function automatic logic is_frac_tick(input int k);
    logic hit = 1'b0;
    for (int i = 0; i < 16; i++) if (FR_TICKS[i] == k) hit = 1'b1;
    return hit;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; resync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div_int = '0; cfg_if.cfg_div_frac = '0;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    check_reset();
    run_int(128);
    $display("integer divisor: cycles 0..128 done");

    // Config mid-bit: accept at os_cnt=5, hold a second offer while not ready
    for (int i = 0; i < 100 && os_cnt != 4'd5; i++) step();
    chk("find_os5", 32'(os_cnt), 5);
    last = cyc;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_int = 16'd6; cfg_if.cfg_div_frac = 4'd0;
    step();
    cfg_if.cfg_div_int = 16'd9;
    chk("cfg_acc_ready", 32'(cfg_if.cfg_ready), 0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (os_tick) begin
        chk("cfg_old_period", 32'(cyc - last), 4);
        last = cyc;
      end
      if (bit_tick) begin
        chk("cfg_ready_rise", 32'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_valid = 1'b0;
        found = 1;
        break;
      end
      chk("cfg_ready_low", 32'(cfg_if.cfg_ready), 0);
    end
    chk("cfg_boundary_seen", 32'(found), 1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (os_tick) break;
    end
    chk("cfg_new_period", 32'(cyc - last), 6);
    chk("cfg_new_os_cnt", 32'(os_cnt), 1);
    $display("config mid-bit: new period from cycle %0d", cyc);

    // en low for 10 cycles right after a tick
    last = cyc; saved_os = int'(os_cnt); saved_bclk = bclk;
    en = 1'b0;
    repeat (10) begin
      step();
      chk("en_no_tick", 32'(os_tick), 0);
      chk("en_os_cnt_hold", 32'(os_cnt), 32'(saved_os));
      chk("en_bclk_hold", 32'(bclk), 32'(saved_bclk));
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (os_tick) break;
    end
    chk("en_resume_gap", 32'(cyc - last), 16);
    chk("en_resume_os_cnt", 32'(os_cnt), 32'((saved_os + 1) % 16));
    $display("enable freeze: resumed tick at cycle %0d", cyc);

    // resync on the cnt==0 cycle (5 cycles after a tick with divisor 6)
    repeat (5) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs_no_tick", 32'(os_tick), 0);
    chk("rs_os_cnt", 32'(os_cnt), 0);
    chk("rs_bclk", 32'(bclk), 1);
    for (int k = 2; k <= 6; k++) begin
      step();
      chk("rs_os_tick", 32'(os_tick), 32'(k == 6));
      chk("rs_os_cnt_run", 32'(os_cnt), 32'(k == 6));
    end
    $display("resync: first tick at cycle %0d", cyc);

    // Divisor 0 clamps to 2; loaded while idle so it activates next cycle
    en = 1'b0;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_int = 16'd0; cfg_if.cfg_div_frac = 4'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("clamp_ready_low", 32'(cfg_if.cfg_ready), 0);
    step();
    chk("clamp_ready_high", 32'(cfg_if.cfg_ready), 1);
    en = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      step();
      chk("clamp_os_tick", 32'(os_tick), 32'(k % 2 == 0));
    end
    $display("clamp: divisor 0 ran at period 2");

    // Fractional divisor 3 + 8/16 then resync
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_int = 16'd3; cfg_if.cfg_div_frac = 4'd8;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("frac_ready_low", 32'(cfg_if.cfg_ready), 0);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("frac_ready_high", 32'(cfg_if.cfg_ready), 1);
    chk("frac_os_cnt0", 32'(os_cnt), 0);
    chk("frac_tick1", 32'(os_tick), 0);
    cnt_ticks = 0;
    for (int k = 2; k <= 55; k++) begin
      step();
      if (os_tick) cnt_ticks++;
      chk("frac_os_tick", 32'(os_tick), 32'(is_frac_tick(k)));
      chk("frac_bit_tick", 32'(bit_tick), 32'(k == 55));
      chk("frac_mid_tick", 32'(mid_tick), 32'(k == 27));
    end
    chk("frac_tick_count", 32'(cnt_ticks), 16);
    $display("fractional: %0d ticks in 56 cycles", cnt_ticks);

    // Reset mid-bit with a config pending
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div_int = 16'd7; cfg_if.cfg_div_frac = 4'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("rst_pend_ready", 32'(cfg_if.cfg_ready), 0);
    repeat (5) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    check_reset();
    run_int(64);
    $display("reset mid-bit: timing restarted with default divisor");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
